// File: rtl/miscv_pipe_pkg.sv
// Shared pipeline types for the MISC-V core: MEM/WB payload layout and bubble constant.
package miscv_pipe_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_RD_W   = 4;

    typedef struct packed {
        logic                  regwrite;
        logic                  regstore;
        logic [DEF_DATA_W-1:0] alu_result;
        logic [DEF_DATA_W-1:0] store_mem;
        logic [DEF_RD_W-1:0]   rd;
    } mem_wb_payload_t;

    localparam mem_wb_payload_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid register: main entry drives the output, skid entry absorbs
// one transfer under back-pressure so in_ready can be registered.
module pipe_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {OCC_EMPTY, OCC_MAIN, OCC_FULL} occ_e;

    occ_e         state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) state_q <= OCC_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: if (in_fire) state_d = OCC_MAIN;
                OCC_MAIN: begin
                    if (in_fire && !out_fire)      state_d = OCC_FULL;
                    else if (!in_fire && out_fire) state_d = OCC_EMPTY;
                end
                OCC_FULL:  if (out_fire) state_d = OCC_MAIN;
                default:   state_d = OCC_EMPTY;
            endcase
        end
    end

    // in_ready depends only on registered occupancy, never on out_ready.
    always_comb begin
        in_ready  = (state_q != OCC_FULL);
        out_valid = (state_q != OCC_EMPTY);
        out_data  = main_q;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state_q)
                OCC_EMPTY: if (in_fire) main_q <= in_data;
                OCC_MAIN: begin
                    if (in_fire && out_fire) main_q <= in_data;
                    else if (in_fire)        skid_q <= in_data;
                end
                OCC_FULL:  if (out_fire) main_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with ready/valid skid buffer, flush and bubble gating.
// Optional stall/bubble statistics counters when MISCV_PIPE_STAT_EN is defined.
module mem_wb_stage
    import miscv_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_W   = DEF_RD_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_regstore,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_mem,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic              out_regstore,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_mem,
    output logic [RD_W-1:0]   out_rd
`ifdef MISCV_PIPE_STAT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    localparam int unsigned PW = 2 + 2 * DATA_W + RD_W;

    logic [PW-1:0]     in_pl, out_pl;
    logic              pl_regwrite, pl_regstore;
    logic [DATA_W-1:0] pl_alu_result, pl_store_mem;
    logic [RD_W-1:0]   pl_rd;

    assign in_pl = {in_regwrite, in_regstore, in_alu_result, in_store_mem, in_rd};
    assign {pl_regwrite, pl_regstore, pl_alu_result, pl_store_mem, pl_rd} = out_pl;

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk       (CLK),
        .reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl)
    );

    // Bubbles present an all-zero payload so the register file is never written.
    always_comb begin
        out_regwrite   = out_valid & pl_regwrite;
        out_regstore   = out_valid & pl_regstore;
        out_alu_result = out_valid ? pl_alu_result : '0;
        out_store_mem  = out_valid ? pl_store_mem  : '0;
        out_rd         = out_valid ? pl_rd         : '0;
    end

`ifdef MISCV_PIPE_STAT_EN
    logic           flush_drop;
    logic [1:0]     bubble_inc;
    logic [CNT_W:0] bubble_sum;

    // A flush discards a held entry unless the only entry leaves this cycle; !in_ready means two held.
    assign flush_drop = flush & (~in_ready | (out_valid & ~out_ready));
    assign bubble_inc = {1'b0, ~out_valid} + {1'b0, flush_drop};
    assign bubble_sum = {1'b0, bubble_cnt} + (CNT_W + 1)'(bubble_inc);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            bubble_cnt <= bubble_sum[CNT_W] ? '1 : bubble_sum[CNT_W-1:0];
        end
    end
`endif

endmodule
